// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default latencies, result record.
// The accumulate ops (MADD family) are only decoded when MD_MADD_EN is defined.
package md_pkg;
    localparam int MD_OP_W            = 4;
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } md_res_t;
endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit HI/LO result generator for the multiply/divide unit.
// Accumulate ops are decoded only when MD_MADD_EN is defined.
module md_calc
    import md_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic [31:0]        hi,
    input  logic [31:0]        lo,
    output logic [31:0]        res_hi,
    output logic [31:0]        res_lo,
    output logic               div_by_zero
);
    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, mag_d, q_mag, r_mag;
    logic [31:0] u_d, uq, ur;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign mag_a = a[31] ? 32'd0 - a : a;
    assign mag_b = b[31] ? 32'd0 - b : b;
    assign mag_d = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag = mag_a / mag_d;
    assign r_mag = mag_a % mag_d;

    assign u_d = (b == 32'd0) ? 32'd1 : b;
    assign uq  = a / u_d;
    assign ur  = a % u_d;

    always_comb begin
        res_hi      = hi;
        res_lo      = lo;
        div_by_zero = 1'b0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                div_by_zero = (b == 32'd0);
                res_lo      = (a[31] ^ b[31]) ? 32'd0 - q_mag : q_mag;
                res_hi      = a[31] ? 32'd0 - r_mag : r_mag;
            end
            MD_DIVU: begin
                div_by_zero = (b == 32'd0);
                res_lo      = uq;
                res_hi      = ur;
            end
`ifdef MD_MADD_EN
            MD_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            MD_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
            MD_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
            MD_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
            default: ;
        endcase
    end
endmodule

// File: rtl/md_unit.sv
// E-stage multi-cycle multiply/divide unit owning HI/LO; busy holds off later MD ops.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) enabled by defining MD_MADD_EN.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic               busy,
    output logic [31:0]        md_out,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    md_res_t          pend;
    logic [31:0]      calc_hi, calc_lo;
    logic             calc_dz;
    logic             is_mul, is_div;

    md_calc u_calc (
        .op          (op),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .res_hi      (calc_hi),
        .res_lo      (calc_lo),
        .div_by_zero (calc_dz)
    );

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        case (op)
            MD_MULT, MD_MULTU: is_mul = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_mul = 1'b1;
`endif
            MD_DIV, MD_DIVU: is_div = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            busy <= 1'b0;
            cnt  <= '0;
            pend <= '0;
        end else if (busy) begin
            // Starts arriving while busy (including on the commit edge) are dropped.
            if (cnt == CNT_W'(1)) begin
                if (!pend.dz) begin
                    hi <= pend.hi;
                    lo <= pend.lo;
                end
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else if (start) begin
            if (is_mul || is_div) begin
                pend <= '{hi: calc_hi, lo: calc_lo, dz: calc_dz};
                cnt  <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                busy <= 1'b1;
            end else if (op == MD_MTHI) begin
                hi <= a;
            end else if (op == MD_MTLO) begin
                lo <= a;
            end
        end
    end

    assign md_out = (op == MD_MFHI) ? hi :
                    (op == MD_MFLO) ? lo : 32'd0;
endmodule
